// File: rtl/regfile_write_buffer.sv
// Posted-write queue for the register-file write port: in-order drain when writeback
// leaves the port idle, plus a youngest-match snoop of pending writes.
module regfile_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              port_busy,
  output logic              ctrl_writeEnable,
  output logic [ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] rd_reg,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  hit_vec;
  logic              push, pop, hs;

  assign full             = (count_q == CW'(DEPTH));
  assign empty            = (count_q == '0);
  assign count            = count_q;
  assign in_ready         = !full;
  assign hs               = in_valid && in_ready;
  // Writes to r0 complete the handshake but are dropped.
  assign push             = hs && (in_reg != '0);
  assign ctrl_writeEnable = !empty && !port_busy;
  assign pop              = ctrl_writeEnable;
  assign ctrl_writeReg    = empty ? '0 : reg_q[rd_ptr_q];
  assign data_writeReg    = empty ? '0 : data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    count_d  = count_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
    end
  end

  // Payload needs no reset: every read of it is qualified by count/valid bits.
  always_ff @(posedge clock) begin
    if (push) begin
      reg_q[wr_ptr_q]  <= in_reg;
      data_q[wr_ptr_q] <= in_data;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign hit_vec[i] = vld_q[i] && (reg_q[i] == rd_reg) && (rd_reg != '0);
  end

  // Walk from head to tail so the youngest match is the last one to win.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (hit_vec[idx]) begin
        rd_hit  = 1'b1;
        rd_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer: one task per scenario with inline checks.
module tb_regfile_write_buffer;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        port_busy;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  rd_reg;
  logic        rd_hit;
  logic [31:0] rd_data;
  logic [2:0]  count;
  logic        full, empty;

  int errs = 0;
  int chks = 0;

  regfile_write_buffer #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .port_busy(port_busy), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .rd_reg(rd_reg), .rd_hit(rd_hit), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  // Advance one edge and settle; inputs are then driven and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_reg = 0; in_data = 0; port_busy = 0; rd_reg = 0;
    ctrl_reset = 1;
    step();
    step();
    ctrl_reset = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    chks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    chks++; if (empty !== 1'b1 || full !== 1'b0) begin errs++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    chks++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
    chks++; if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'd0)
      begin errs++; $display("FAIL reset_port got we=%b reg=%0d data=%h exp 0", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
    chks++; if (rd_hit !== 1'b0 || rd_data !== 32'd0) begin errs++; $display("FAIL reset_snoop got hit=%b data=%h exp 0", rd_hit, rd_data); end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1; in_reg = 5'd3; in_data = 32'hA5A5A5A5;
    #1;
    chks++; if (ctrl_writeEnable !== 1'b0) begin errs++; $display("FAIL single_no_bypass got we=%b exp=0", ctrl_writeEnable); end
    step();
    in_valid = 0;
    #1;
    chks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'hA5A5A5A5)
      begin errs++; $display("FAIL single_write got we=%b reg=%0d data=%h exp 1/3/a5a5a5a5", ctrl_writeEnable, ctrl_writeReg, data_writeReg); end
    step();
    chks++; if (empty !== 1'b1 || ctrl_writeEnable !== 1'b0) begin errs++; $display("FAIL single_drained got empty=%b we=%b exp 1/0", empty, ctrl_writeEnable); end
  endtask

  task automatic test_full_stall();
    do_reset();
    port_busy = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_reg = 5'(i); in_data = 32'h100 + 32'(i);
      step();
    end
    chks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4)
      begin errs++; $display("FAIL full_flags got full=%b rdy=%b cnt=%0d exp 1/0/4", full, in_ready, count); end
    chks++; if (ctrl_writeEnable !== 1'b0) begin errs++; $display("FAIL full_busy_we got=%b exp=0", ctrl_writeEnable); end
    in_valid = 1; in_reg = 5'd5; in_data = 32'h105;
    step();
    chks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errs++; $display("FAIL fifth_held got cnt=%0d rdy=%b exp 4/0", count, in_ready); end
    port_busy = 0;
    // Expected drain: 1,2,3,4 back to back, then the held 5th.
    for (int i = 1; i <= 5; i++) begin
      #1;
      chks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'(i) || data_writeReg !== 32'h100 + 32'(i))
        begin errs++; $display("FAIL drain_%0d got we=%b reg=%0d data=%h exp reg=%0d", i, ctrl_writeEnable, ctrl_writeReg, data_writeReg, i); end
      if (i == 2) begin
        chks++; if (in_ready !== 1'b1 || count !== 3'd3) begin errs++; $display("FAIL full_fell got rdy=%b cnt=%0d exp 1/3", in_ready, count); end
      end
      step();
      if (i == 2) in_valid = 0;
    end
    chks++; if (empty !== 1'b1 || ctrl_writeEnable !== 1'b0) begin errs++; $display("FAIL full_end got empty=%b we=%b exp 1/0", empty, ctrl_writeEnable); end
  endtask

  task automatic test_snoop();
    do_reset();
    port_busy = 1;
    in_valid = 1; in_reg = 5'd7; in_data = 32'h11;
    step();
    in_data = 32'h22;
    rd_reg = 5'd7;
    #1;
    chks++; if (rd_hit !== 1'b1 || rd_data !== 32'h11) begin errs++; $display("FAIL snoop_push_invisible got hit=%b data=%h exp 1/11", rd_hit, rd_data); end
    step();
    in_valid = 0;
    #1;
    chks++; if (rd_hit !== 1'b1 || rd_data !== 32'h22) begin errs++; $display("FAIL snoop_youngest got hit=%b data=%h exp 1/22", rd_hit, rd_data); end
    rd_reg = 5'd9;
    #1;
    chks++; if (rd_hit !== 1'b0 || rd_data !== 32'd0) begin errs++; $display("FAIL snoop_miss got hit=%b data=%h exp 0/0", rd_hit, rd_data); end
    rd_reg = 5'd7;
    port_busy = 0;
    step();
    chks++; if (ctrl_writeEnable !== 1'b1 || data_writeReg !== 32'h22 || rd_hit !== 1'b1 || rd_data !== 32'h22)
      begin errs++; $display("FAIL snoop_pop_visible got we=%b wd=%h hit=%b data=%h exp 1/22/1/22", ctrl_writeEnable, data_writeReg, rd_hit, rd_data); end
    step();
    chks++; if (rd_hit !== 1'b0 || rd_data !== 32'd0) begin errs++; $display("FAIL snoop_drained got hit=%b data=%h exp 0/0", rd_hit, rd_data); end
    rd_reg = 0;
  endtask

  task automatic test_reg0();
    do_reset();
    port_busy = 1;
    in_valid = 1; in_reg = 5'd0; in_data = 32'hDEAD;
    #1;
    chks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reg0_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 0;
    port_busy = 0;
    rd_reg = 5'd0;
    #1;
    chks++; if (count !== 3'd0 || ctrl_writeEnable !== 1'b0) begin errs++; $display("FAIL reg0_dropped got cnt=%0d we=%b exp 0/0", count, ctrl_writeEnable); end
    chks++; if (rd_hit !== 1'b0) begin errs++; $display("FAIL reg0_snoop got hit=%b exp=0", rd_hit); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  qr[$];
    logic [31:0] qd[$];
    do_reset();
    port_busy = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_reg = 5'(10 + i); in_data = 32'(100 + i);
      qr.push_back(in_reg); qd.push_back(in_data);
      step();
    end
    port_busy = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_reg = 5'(12 + i); in_data = 32'(200 + i);
      #1;
      chks++; if (count !== 3'd2) begin errs++; $display("FAIL b2b_count_%0d got=%0d exp=2", i, count); end
      chks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== qr[0] || data_writeReg !== qd[0])
        begin errs++; $display("FAIL b2b_order_%0d got we=%b reg=%0d data=%0d exp reg=%0d data=%0d", i, ctrl_writeEnable, ctrl_writeReg, data_writeReg, qr[0], qd[0]); end
      qr.push_back(in_reg); qd.push_back(in_data);
      void'(qr.pop_front()); void'(qd.pop_front());
      step();
    end
    in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== qr[0] || data_writeReg !== qd[0])
        begin errs++; $display("FAIL b2b_tail_%0d got reg=%0d data=%0d exp reg=%0d data=%0d", i, ctrl_writeReg, data_writeReg, qr[0], qd[0]); end
      void'(qr.pop_front()); void'(qd.pop_front());
      step();
    end
    chks++; if (empty !== 1'b1) begin errs++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    port_busy = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_reg = 5'(20 + i); in_data = 32'(300 + i);
      step();
    end
    in_valid = 0;
    port_busy = 0;
    #1;
    chks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd20) begin errs++; $display("FAIL mid_pre got we=%b reg=%0d exp 1/20", ctrl_writeEnable, ctrl_writeReg); end
    ctrl_reset = 1;
    #1;
    chks++; if (ctrl_writeEnable !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || ctrl_writeReg !== 5'd0)
      begin errs++; $display("FAIL mid_async got we=%b cnt=%0d rdy=%b reg=%0d exp 0/0/1/0", ctrl_writeEnable, count, in_ready, ctrl_writeReg); end
    ctrl_reset = 0;
    step();
    chks++; if (ctrl_writeEnable !== 1'b0 || count !== 3'd0 || empty !== 1'b1)
      begin errs++; $display("FAIL mid_after got we=%b cnt=%0d empty=%b exp 0/0/1", ctrl_writeEnable, count, empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_stall();
    test_snoop();
    test_reg0();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
